// File: rtl/mem_stage_sequencer.sv
// MEM-stage data-memory sequencer: single (LDR/STR/LDB/STB) and two-step (LDI/STI) dcache accesses.
// Optional MEM_TIMEOUT_EN adds a per-access response timeout with a sticky err_out flag.
module mem_stage_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             indirect_enable,
  input  logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic             stall_out,
  output logic             done_out,
  output logic [WIDTH-1:0] rdata_out,
  output logic             err_out
);

  typedef enum logic [2:0] {IDLE, IND, RD, WR, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] wdata_q;
  logic [1:0]       be_q;
  logic             st_q;
  logic             accept;

  // Word accesses are halfword-aligned; byte accesses keep the full address.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a, input logic [1:0] be);
    return (be == 2'b11) ? {a[WIDTH-1:1], 1'b0} : a;
  endfunction

  assign accept = valid_in & (mem_read | mem_write | indirect_enable);

  // Stall is raised in the accepting cycle itself so EX/MEM holds the instruction.
  assign stall_out = (state == IND) || (state == RD) || (state == WR) ||
                     ((state == IDLE) && accept);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wdata_q          <= '0;
      be_q             <= '0;
      st_q             <= 1'b0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      done_out         <= 1'b0;
      rdata_out        <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt         <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wdata_q <= wdata_in;
            be_q    <= mem_byte_enable;
            st_q    <= mem_write & ~mem_read;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (indirect_enable) begin
              state            <= IND;
              dmem_read        <= 1'b1;
              dmem_address     <= align(addr_in, 2'b11);
              dmem_byte_enable <= 2'b11;
            end else if (mem_read) begin
              state            <= RD;
              dmem_read        <= 1'b1;
              dmem_address     <= align(addr_in, mem_byte_enable);
              dmem_byte_enable <= mem_byte_enable;
            end else begin
              state            <= WR;
              dmem_write       <= 1'b1;
              dmem_address     <= align(addr_in, mem_byte_enable);
              dmem_wdata       <= wdata_in;
              dmem_byte_enable <= mem_byte_enable;
            end
          end
        end
        IND: begin
          // Pointer returned: the final access targets it directly.
          if (dmem_resp) begin
            dmem_address     <= align(dmem_rdata, be_q);
            dmem_byte_enable <= be_q;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (st_q) begin
              state      <= WR;
              dmem_read  <= 1'b0;
              dmem_write <= 1'b1;
              dmem_wdata <= wdata_q;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (dmem_resp) begin
            rdata_out <= dmem_rdata;
            dmem_read <= 1'b0;
            done_out  <= 1'b1;
            state     <= DONE;
          end
        end
        WR: begin
          if (dmem_resp) begin
            dmem_write <= 1'b0;
            done_out   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Abandon an access the dcache never answers; loads return zero.
      if (((state == IND) || (state == RD) || (state == WR)) && !dmem_resp) begin
        if (wait_cnt == TIMEOUT_LAST) begin
          err_q      <= 1'b1;
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          done_out   <= 1'b1;
          state      <= DONE;
          if ((state == RD) || ((state == IND) && !st_q)) rdata_out <= '0;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer with a delay-programmable dcache responder.
module tb_mem_stage_sequencer;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic        indirect_enable;
  logic [1:0]  mem_byte_enable;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        stall_out;
  logic        done_out;
  logic [15:0] rdata_out;
  logic        err_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:65535];
  int          resp_delay = 0;
  int          resp_cnt   = 0;
  int          wr_cnt     = 0;
  int          rd_cnt     = 0;
  logic [15:0] last_wa    = '0;
  logic [15:0] last_wd    = '0;
  logic [1:0]  last_wbe   = '0;

  mem_stage_sequencer #(.WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .indirect_enable  (indirect_enable),
    .mem_byte_enable  (mem_byte_enable),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .stall_out        (stall_out),
    .done_out         (done_out),
    .rdata_out        (rdata_out),
    .err_out          (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dcache model: answers a held request after resp_delay idle cycles.
  always @(negedge clk) begin
    dmem_resp = 1'b0;
    if (rst) begin
      resp_cnt   = 0;
      dmem_rdata = '0;
    end else if (dmem_read || dmem_write) begin
      if (resp_cnt >= resp_delay) begin
        dmem_resp = 1'b1;
        resp_cnt  = 0;
        if (dmem_write) begin
          wr_cnt++;
          last_wa  = dmem_address;
          last_wd  = dmem_wdata;
          last_wbe = dmem_byte_enable;
        end else begin
          rd_cnt++;
          dmem_rdata = mem[dmem_address];
        end
      end else begin
        resp_cnt++;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic ind,
                       input logic [1:0] be, input logic [15:0] a, input logic [15:0] wd);
    valid_in        = v;
    mem_read        = rd;
    mem_write       = wr;
    indirect_enable = ind;
    mem_byte_enable = be;
    addr_in         = a;
    wdata_in        = wd;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    mem[16'h3000] = 16'hBEEF;
    mem[16'h1000] = 16'h4000;
    mem[16'h4000] = 16'h1234;
    tick();
    tick();
    check("rst_read",   16'(dmem_read),    16'h0);
    check("rst_write",  16'(dmem_write),   16'h0);
    check("rst_addr",   dmem_address,      16'h0);
    check("rst_stall",  16'(stall_out),    16'h0);
    check("rst_done",   16'(done_out),     16'h0);
    check("rst_rdata",  rdata_out,         16'h0);
    check("rst_err",    16'(err_out),      16'h0);
    rst = 1'b0;
    tick();

    // Non-memory instruction passes straight through
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h1234, 16'h0);
    #1 check("add_stall", 16'(stall_out), 16'h0);
    tick();
    check("add_read",  16'(dmem_read),  16'h0);
    check("add_write", 16'(dmem_write), 16'h0);
    check("add_done",  16'(done_out),   16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);

    // LDR word at odd address
    resp_delay = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3001, 16'h0);
    #1 check("ldr_stall_idle", 16'(stall_out), 16'h1);
    tick();
    check("ldr_read",     16'(dmem_read),      16'h1);
    check("ldr_addr",     dmem_address,        16'h3000);
    check("ldr_be",       16'(dmem_byte_enable), 16'h3);
    check("ldr_stall_rd", 16'(stall_out),      16'h1);
    tick();
    check("ldr_done",     16'(done_out),       16'h1);
    check("ldr_stall_dn", 16'(stall_out),      16'h0);
    check("ldr_rdata",    rdata_out,           16'hBEEF);
    check("ldr_req_drop", 16'(dmem_read),      16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check("ldr_done_pulse", 16'(done_out), 16'h0);
    check("ldr_rd_cnt",     16'(rd_cnt),   16'h1);

    // STB high lane
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 16'h2005, 16'h4141);
    tick();
    check("stb_write", 16'(dmem_write),       16'h1);
    check("stb_read",  16'(dmem_read),        16'h0);
    check("stb_addr",  dmem_address,          16'h2005);
    check("stb_be",    16'(dmem_byte_enable), 16'h2);
    check("stb_wdata", dmem_wdata,            16'h4141);
    tick();
    check("stb_done",   16'(done_out), 16'h1);
    check("stb_rdata",  rdata_out,     16'hBEEF);
    check("stb_wr_cnt", 16'(wr_cnt),   16'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

    // LDI: pointer fetch then data fetch
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 16'h1000, 16'h0);
    tick();
    check("ldi_ind_read", 16'(dmem_read),       16'h1);
    check("ldi_ind_addr", dmem_address,         16'h1000);
    check("ldi_ind_be",   16'(dmem_byte_enable), 16'h3);
    tick();
    check("ldi_rd_read",  16'(dmem_read), 16'h1);
    check("ldi_rd_addr",  dmem_address,   16'h4000);
    check("ldi_rd_done0", 16'(done_out),  16'h0);
    tick();
    check("ldi_done",  16'(done_out), 16'h1);
    check("ldi_rdata", rdata_out,     16'h1234);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

    // STI with slow dcache
    mem[16'h1000] = 16'h5000;
    resp_delay = 5;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 16'h1000, 16'h00FF);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sti_ind_stall", 16'(stall_out), 16'h1);
      check("sti_ind_addr",  dmem_address,   16'h1000);
      check("sti_ind_done",  16'(done_out),  16'h0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sti_wr_stall", 16'(stall_out),  16'h1);
      check("sti_wr_write", 16'(dmem_write), 16'h1);
      check("sti_wr_addr",  dmem_address,    16'h5000);
      check("sti_wr_wdata", dmem_wdata,      16'h00FF);
    end
    tick();
    check("sti_done",    16'(done_out), 16'h1);
    check("sti_wr_cnt",  16'(wr_cnt),   16'h2);
    check("sti_last_wa", last_wa,       16'h5000);
    check("sti_last_wd", last_wd,       16'h00FF);
    check("sti_rdata",   rdata_out,     16'h1234);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    check("sti_done_pulse", 16'(done_out), 16'h0);

    // Asynchronous reset in the middle of a read
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3001, 16'h0);
    tick();
    check("rstrd_read", 16'(dmem_read), 16'h1);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    #1;
    check("rstrd_read0",  16'(dmem_read), 16'h0);
    check("rstrd_stall0", 16'(stall_out), 16'h0);
    check("rstrd_addr0",  dmem_address,   16'h0);
    check("rstrd_rdata0", rdata_out,      16'h0);
    tick();
    rst = 1'b0;
    tick();

    // Read and write both set without indirect behaves as a read
    resp_delay = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h3001, 16'h5555);
    tick();
    check("rw_read",  16'(dmem_read),  16'h1);
    check("rw_write", 16'(dmem_write), 16'h0);
    tick();
    check("rw_done",   16'(done_out), 16'h1);
    check("rw_rdata",  rdata_out,     16'hBEEF);
    check("rw_wr_cnt", 16'(wr_cnt),   16'h2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Unanswered load times out after four wait cycles
    resp_delay = 1000;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 16'h3000, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_stall", 16'(stall_out), 16'h1);
      check("to_done0", 16'(done_out),  16'h0);
    end
    tick();
    check("to_done",  16'(done_out), 16'h1);
    check("to_err",   16'(err_out),  16'h1);
    check("to_rdata", rdata_out,     16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    tick();
    tick();
    check("to_err_sticky", 16'(err_out), 16'h1);
`else
    check("err_tied", 16'(err_out), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
